// File: rtl/load_align_wb.sv
// load_align_wb: load alignment and writeback unit.
// Accepts one load request at a time, reads one or two aligned memory beats,
// extracts the addressed bytes, sign/zero extends them and presents the result
// on a registered writeback port that is held until the consumer accepts it.
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   req_valid/req_ready   load request handshake
//   req_funct3/addr/rd    load type, byte address, destination tag
//   mem_req_valid/ready   bus read request handshake, mem_req_addr aligned
//   mem_rsp_valid/data    one-cycle read data pulse, little-endian
//   wb_valid/wb_ready     writeback handshake
//   wb_rd/wb_data/wb_err  result tag, extended data, error flag
module load_align_wb #(
  parameter int XLEN     = 32,
  parameter int SPLIT_EN = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      req_funct3,
  input  logic [31:0]     req_addr,
  input  logic [4:0]      req_rd,
  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  output logic [31:0]     mem_req_addr,
  input  logic            mem_rsp_valid,
  input  logic [XLEN-1:0] mem_rsp_data,
  output logic            wb_valid,
  input  logic            wb_ready,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_data,
  output logic            wb_err
);

  localparam int NB   = XLEN / 8;
  localparam int OFFW = $clog2(NB);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ0 = 3'd1,
    RSP0 = 3'd2,
    REQ1 = 3'd3,
    RSP1 = 3'd4,
    WB   = 3'd5
  } state_t;

  state_t            state_r, next_state_s;
  logic [2:0]        funct3_r;
  logic [OFFW-1:0]   off_r;
  logic [4:0]        rd_r;
  logic              cross_r;
  logic [XLEN-1:0]   beat0_r;
  logic              req_ready_r, mem_req_valid_r;
  logic [31:0]       mem_req_addr_r;
  logic              wb_valid_r, wb_err_r;
  logic [4:0]        wb_rd_r;
  logic [XLEN-1:0]   wb_data_r;

  logic [OFFW-1:0]   req_off_s;
  logic [4:0]        req_size_s;
  logic              req_cross_s, req_illegal_s, req_fail_s, accept_s;
  logic              cap0_s, wb_load_s;
  logic [XLEN-1:0]   lo_beat_s, hi_beat_s, raw_s, ext_s;

  // Truncate the shifted value to the access size and extend it to XLEN.
  // Size casts keep the signedness of their operand, so $signed() gives
  // sign extension; a same-width cast is a plain pass-through.
  function automatic logic [XLEN-1:0] extend(input logic [2:0] f3, input logic [XLEN-1:0] v);
    logic [XLEN-1:0] r;
    case (f3)
      3'b000:  r = XLEN'($signed(v[7:0]));
      3'b001:  r = XLEN'($signed(v[15:0]));
      3'b010:  r = XLEN'($signed(v[31:0]));
      3'b100:  r = XLEN'(v[7:0]);
      3'b101:  r = XLEN'(v[15:0]);
      3'b110:  r = XLEN'(v[31:0]);
      default: r = v;
    endcase
    return r;
  endfunction

  // Decode the incoming request: size, line crossing and legality.
  always_comb begin
    req_off_s = req_addr[OFFW-1:0];
    case (req_funct3[1:0])
      2'b00:   req_size_s = 5'd1;
      2'b01:   req_size_s = 5'd2;
      2'b10:   req_size_s = 5'd4;
      default: req_size_s = 5'd8;
    endcase
    req_cross_s = (5'(req_off_s) + req_size_s) > 5'(NB);
    case (req_funct3)
      3'b111:         req_illegal_s = 1'b1;
      3'b011, 3'b110: req_illegal_s = (XLEN == 32);
      default:        req_illegal_s = 1'b0;
    endcase
    req_fail_s = req_illegal_s || (req_cross_s && (SPLIT_EN == 0));
    accept_s   = req_valid && req_ready_r;
  end

  // Assemble {beat1, beat0}; beat1 is zero for a single-beat load.
  always_comb begin
    if (state_r == RSP1) begin
      lo_beat_s = beat0_r;
      hi_beat_s = mem_rsp_data;
    end else begin
      lo_beat_s = mem_rsp_data;
      hi_beat_s = {XLEN{1'b0}};
    end
    raw_s = XLEN'({hi_beat_s, lo_beat_s} >> {off_r, 3'b000});
    ext_s = extend(funct3_r, raw_s);
  end

  // Next-state logic and per-state capture strobes.
  always_comb begin
    next_state_s = state_r;
    cap0_s       = 1'b0;
    wb_load_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          if (req_fail_s) begin
            next_state_s = WB;
          end else begin
            next_state_s = REQ0;
          end
        end else begin
          next_state_s = IDLE;
        end
      end
      REQ0: begin
        if (mem_req_ready) begin
          next_state_s = RSP0;
        end else begin
          next_state_s = REQ0;
        end
      end
      RSP0: begin
        if (mem_rsp_valid) begin
          cap0_s = 1'b1;
          if (cross_r) begin
            next_state_s = REQ1;
          end else begin
            next_state_s = WB;
            wb_load_s    = 1'b1;
          end
        end else begin
          next_state_s = RSP0;
        end
      end
      REQ1: begin
        if (mem_req_ready) begin
          next_state_s = RSP1;
        end else begin
          next_state_s = REQ1;
        end
      end
      RSP1: begin
        if (mem_rsp_valid) begin
          next_state_s = WB;
          wb_load_s    = 1'b1;
        end else begin
          next_state_s = RSP1;
        end
      end
      WB: begin
        if (wb_ready) begin
          next_state_s = IDLE;
        end else begin
          next_state_s = WB;
        end
      end
      default: next_state_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Capture request fields and the first beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      funct3_r <= 3'd0;
      off_r    <= {OFFW{1'b0}};
      rd_r     <= 5'd0;
      cross_r  <= 1'b0;
      beat0_r  <= {XLEN{1'b0}};
    end else begin
      if (accept_s) begin
        funct3_r <= req_funct3;
        off_r    <= req_off_s;
        rd_r     <= req_rd;
        cross_r  <= req_cross_s;
      end
      if (cap0_s) begin
        beat0_r <= mem_rsp_data;
      end
    end
  end

  // Registered request-side and bus outputs, derived from the next state so
  // they line up with the state they belong to. req_ready stays low in the
  // first cycle after reset and rises on the first clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_ready_r     <= 1'b0;
      mem_req_valid_r <= 1'b0;
      mem_req_addr_r  <= 32'd0;
    end else begin
      req_ready_r     <= (next_state_s == IDLE);
      mem_req_valid_r <= (next_state_s == REQ0) || (next_state_s == REQ1);
      if (accept_s && !req_fail_s) begin
        mem_req_addr_r <= {req_addr[31:OFFW], {OFFW{1'b0}}};
      end else if (cap0_s && cross_r) begin
        // Second beat: next line, wrapping at 2^32.
        mem_req_addr_r <= mem_req_addr_r + 32'(NB);
      end
    end
  end

  // Writeback registers, loaded on entry to WB and held until accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid_r <= 1'b0;
      wb_err_r   <= 1'b0;
      wb_rd_r    <= 5'd0;
      wb_data_r  <= {XLEN{1'b0}};
    end else if (accept_s && req_fail_s) begin
      wb_valid_r <= 1'b1;
      wb_err_r   <= 1'b1;
      wb_rd_r    <= req_rd;
      wb_data_r  <= {XLEN{1'b0}};
    end else if (wb_load_s) begin
      wb_valid_r <= 1'b1;
      wb_err_r   <= 1'b0;
      wb_rd_r    <= rd_r;
      wb_data_r  <= ext_s;
    end else if ((state_r == WB) && wb_ready) begin
      wb_valid_r <= 1'b0;
    end
  end

  assign req_ready     = req_ready_r;
  assign mem_req_valid = mem_req_valid_r;
  assign mem_req_addr  = mem_req_addr_r;
  assign wb_valid      = wb_valid_r;
  assign wb_rd         = wb_rd_r;
  assign wb_data       = wb_data_r;
  assign wb_err        = wb_err_r;

endmodule

// File: tb/tb_load_align_wb.sv
// tb_load_align_wb: scoreboard bench for load_align_wb.
// Three instances: index 0 = XLEN 32 with split loads, 1 = XLEN 32 without
// split loads, 2 = XLEN 64. A bench-side memory responder answers each bus
// read one cycle after its handshake with data queued by the stimulus.
module tb_load_align_wb;

  typedef struct {
    int          d;
    logic [31:0] addr;
    logic [63:0] data;
  } beat_t;

  typedef struct {
    int          d;
    logic [4:0]  rd;
    logic [63:0] data;
    logic        err;
  } exp_t;

  logic        clk, rst_n;
  logic        req_valid [3];
  logic [2:0]  req_funct3 [3];
  logic [31:0] req_addr [3];
  logic [4:0]  req_rd [3];
  logic        mem_req_ready [3];
  logic        mem_rsp_valid [3];
  logic [31:0] rsp_lo [2];
  logic [63:0] rsp64;
  logic        wb_ready [3];

  wire         req_ready [3];
  wire         mem_req_valid [3];
  wire  [31:0] mem_req_addr [3];
  wire         wb_valid [3];
  wire  [4:0]  wb_rd [3];
  wire  [31:0] wbd_lo [2];
  wire  [63:0] wbd64;
  wire         wb_err [3];

  logic        manual [3];
  logic        pend [3];
  logic [63:0] pdata [3];

  beat_t beat_q[$];
  exp_t  exp_q[$];
  int    n_checks = 0;
  int    n_errors = 0;

  load_align_wb #(.XLEN(32), .SPLIT_EN(1)) u_dut32 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_funct3(req_funct3[0]),
    .req_addr(req_addr[0]), .req_rd(req_rd[0]),
    .mem_req_valid(mem_req_valid[0]), .mem_req_ready(mem_req_ready[0]),
    .mem_req_addr(mem_req_addr[0]), .mem_rsp_valid(mem_rsp_valid[0]),
    .mem_rsp_data(rsp_lo[0]),
    .wb_valid(wb_valid[0]), .wb_ready(wb_ready[0]), .wb_rd(wb_rd[0]),
    .wb_data(wbd_lo[0]), .wb_err(wb_err[0])
  );

  load_align_wb #(.XLEN(32), .SPLIT_EN(0)) u_dut32_nosplit (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_funct3(req_funct3[1]),
    .req_addr(req_addr[1]), .req_rd(req_rd[1]),
    .mem_req_valid(mem_req_valid[1]), .mem_req_ready(mem_req_ready[1]),
    .mem_req_addr(mem_req_addr[1]), .mem_rsp_valid(mem_rsp_valid[1]),
    .mem_rsp_data(rsp_lo[1]),
    .wb_valid(wb_valid[1]), .wb_ready(wb_ready[1]), .wb_rd(wb_rd[1]),
    .wb_data(wbd_lo[1]), .wb_err(wb_err[1])
  );

  load_align_wb #(.XLEN(64), .SPLIT_EN(1)) u_dut64 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[2]), .req_ready(req_ready[2]), .req_funct3(req_funct3[2]),
    .req_addr(req_addr[2]), .req_rd(req_rd[2]),
    .mem_req_valid(mem_req_valid[2]), .mem_req_ready(mem_req_ready[2]),
    .mem_req_addr(mem_req_addr[2]), .mem_rsp_valid(mem_rsp_valid[2]),
    .mem_rsp_data(rsp64),
    .wb_valid(wb_valid[2]), .wb_ready(wb_ready[2]), .wb_rd(wb_rd[2]),
    .wb_data(wbd64), .wb_err(wb_err[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count one comparison and report it when it differs.
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [63:0] wbd(input int d);
    if (d == 2) return wbd64;
    else        return {32'h0, wbd_lo[d[0]]};
  endfunction

  // Memory responder: note a read handshake at the negedge, answer for one
  // cycle after the following posedge.
  always begin
    beat_t b;
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      pend[d] = 1'b0;
      if (mem_req_valid[d] === 1'b1 && mem_req_ready[d]) begin
        check("beat_avail", 64'(beat_q.size() > 0), 64'd1);
        if (beat_q.size() > 0) begin
          b = beat_q.pop_front();
          check("beat_dut", 64'(d), 64'(b.d));
          check("mem_addr", 64'(mem_req_addr[d]), 64'(b.addr));
          pend[d]  = 1'b1;
          pdata[d] = b.data;
        end
      end
    end
    @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      if (!manual[d]) begin
        mem_rsp_valid[d] = pend[d];
        if (d == 2) rsp64 = pdata[2];
        else        rsp_lo[d[0]] = pdata[d][31:0];
      end
    end
  end

  // Writeback monitor: compare each accepted result against the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    for (int d = 0; d < 3; d++) begin
      if (wb_valid[d] === 1'b1 && wb_ready[d]) begin
        check("sb_nonempty", 64'(exp_q.size() > 0), 64'd1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("wb_dut", 64'(d), 64'(e.d));
          check("wb_rd", 64'(wb_rd[d]), 64'(e.rd));
          check("wb_data", wbd(d), e.data);
          check("wb_err", 64'(wb_err[d]), 64'(e.err));
        end
      end
    end
  end

  task automatic beat(input int d, input logic [31:0] addr, input logic [63:0] data);
    beat_q.push_back('{d, addr, data});
  endtask

  task automatic check_reset_outputs(input int d);
    check("rst_req_ready", 64'(req_ready[d]), 64'd0);
    check("rst_mem_valid", 64'(mem_req_valid[d]), 64'd0);
    check("rst_mem_addr", 64'(mem_req_addr[d]), 64'd0);
    check("rst_wb_valid", 64'(wb_valid[d]), 64'd0);
    check("rst_wb_rd", 64'(wb_rd[d]), 64'd0);
    check("rst_wb_data", wbd(d), 64'd0);
    check("rst_wb_err", 64'(wb_err[d]), 64'd0);
  endtask

  // Wait (bounded) for acceptance, then drop req_valid after the edge.
  task automatic accept(input int d);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (req_ready[d] !== 1'b1 && n < 40);
    check("accept", 64'(req_ready[d]), 64'd1);
    @(posedge clk);
    #1;
    req_valid[d] = 1'b0;
  endtask

  // Drive one request and return the cycles from acceptance to wb_valid.
  task automatic issue(input int d, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [4:0] rd, output int lat);
    @(posedge clk);
    #1;
    req_valid[d]  = 1'b1;
    req_funct3[d] = f3;
    req_addr[d]   = addr;
    req_rd[d]     = rd;
    accept(d);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (wb_valid[d] !== 1'b1 && lat < 40);
    check("wb_seen", 64'(wb_valid[d]), 64'd1);
  endtask

  task automatic run(input int d, input logic [2:0] f3, input logic [31:0] addr,
                     input logic [4:0] rd, input logic [63:0] edata, input logic err,
                     input int elat);
    int lat;
    exp_q.push_back('{d, rd, edata, err});
    issue(d, f3, addr, rd, lat);
    check("latency", 64'(lat), 64'(elat));
    @(posedge clk);
    #1;
    check("beats_used", 64'(beat_q.size()), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    rst_n = 1'b1;
    rsp64 = 64'd0;
    for (int d = 0; d < 3; d++) begin
      req_valid[d] = 1'b0; req_funct3[d] = 3'd0; req_addr[d] = 32'd0; req_rd[d] = 5'd0;
      mem_req_ready[d] = 1'b1; mem_rsp_valid[d] = 1'b0; wb_ready[d] = 1'b1;
      manual[d] = 1'b0; pend[d] = 1'b0; pdata[d] = 64'd0;
    end
    rsp_lo[0] = 32'd0;
    rsp_lo[1] = 32'd0;
    #1 rst_n = 1'b0;
    #1;
    for (int d = 0; d < 3; d++) check_reset_outputs(d);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rdy_before_edge", 64'(req_ready[0]), 64'd0);
    @(posedge clk);
    #1;
    check("rdy_first_edge", 64'(req_ready[0]), 64'd1);

    // XLEN=32, split enabled
    beat(0, 32'h1000, 64'h80FF_1234);
    run(0, 3'b000, 32'h1003, 5'd1, 64'hFFFF_FF80, 1'b0, 3);
    beat(0, 32'h2000, 64'hBEEF_0000);
    run(0, 3'b101, 32'h2002, 5'd2, 64'h0000_BEEF, 1'b0, 3);
    // bytes 0x3003..0x3006 are 44 55 66 77
    beat(0, 32'h3000, 64'h4433_2211);
    beat(0, 32'h3004, 64'h8877_6655);
    run(0, 3'b010, 32'h3003, 5'd3, 64'h7766_5544, 1'b0, 5);
    beat(0, 32'h1000, 64'h0080_0100);
    run(0, 3'b001, 32'h1001, 5'd4, 64'hFFFF_8001, 1'b0, 3);
    beat(0, 32'h1000, 64'h00F0_0000);
    run(0, 3'b100, 32'h1002, 5'd5, 64'h0000_00F0, 1'b0, 3);
    beat(0, 32'h1000, 64'hAB00_0000);
    beat(0, 32'h1004, 64'h0000_00CD);
    run(0, 3'b001, 32'h1003, 5'd6, 64'hFFFF_CDAB, 1'b0, 5);
    beat(0, 32'hFFFF_FFFC, 64'h1100_0000);
    beat(0, 32'h0000_0000, 64'h0000_0022);
    run(0, 3'b001, 32'hFFFF_FFFF, 5'd7, 64'h0000_2211, 1'b0, 5);
    beat(0, 32'h2000, 64'h1234_5678);
    run(0, 3'b010, 32'h2000, 5'd8, 64'h1234_5678, 1'b0, 3);
    run(0, 3'b111, 32'h2000, 5'd9, 64'd0, 1'b1, 1);
    run(0, 3'b011, 32'h2000, 5'd10, 64'd0, 1'b1, 1);
    run(0, 3'b110, 32'h2000, 5'd11, 64'd0, 1'b1, 1);

    // XLEN=32, split disabled
    run(1, 3'b010, 32'h3003, 5'd12, 64'd0, 1'b1, 1);
    run(1, 3'b011, 32'h3000, 5'd13, 64'd0, 1'b1, 1);
    beat(1, 32'h1000, 64'h7F00_0000);
    run(1, 3'b000, 32'h1003, 5'd14, 64'h0000_007F, 1'b0, 3);
    beat(1, 32'h3000, 64'h5566_7788);
    run(1, 3'b010, 32'h3000, 5'd15, 64'h5566_7788, 1'b0, 3);

    // XLEN=64
    beat(2, 32'h8, 64'h0000_0000_9000_0001);
    run(2, 3'b110, 32'h8, 5'd16, 64'h0000_0000_9000_0001, 1'b0, 3);
    beat(2, 32'h8, 64'h0000_0000_9000_0001);
    run(2, 3'b010, 32'h8, 5'd17, 64'hFFFF_FFFF_9000_0001, 1'b0, 3);
    beat(2, 32'h10, 64'h0123_4567_89AB_CDEF);
    run(2, 3'b011, 32'h10, 5'd18, 64'h0123_4567_89AB_CDEF, 1'b0, 3);
    beat(2, 32'h8, 64'h8000_0000_0000_0000);
    run(2, 3'b010, 32'hC, 5'd19, 64'hFFFF_FFFF_8000_0000, 1'b0, 3);
    beat(2, 32'h0, 64'hAAAA_AAAA_1111_1111);
    beat(2, 32'h8, 64'h2222_2222_BBBB_BBBB);
    run(2, 3'b011, 32'h4, 5'd20, 64'hBBBB_BBBB_AAAA_AAAA, 1'b0, 5);
    run(2, 3'b111, 32'h0, 5'd21, 64'd0, 1'b1, 1);

    // Writeback back-pressure: outputs held, no new acceptance.
    wb_ready[0] = 1'b0;
    beat(0, 32'h2000, 64'hCAFE_F00D);
    exp_q.push_back('{0, 5'd22, 64'hCAFE_F00D, 1'b0});
    issue(0, 3'b010, 32'h2000, 5'd22, lat);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("stall_valid", 64'(wb_valid[0]), 64'd1);
      check("stall_data", wbd(0), 64'hCAFE_F00D);
      check("stall_rd", 64'(wb_rd[0]), 64'd22);
      check("stall_rdy", 64'(req_ready[0]), 64'd0);
    end
    @(posedge clk);
    #1 wb_ready[0] = 1'b1;
    @(negedge clk);
    check("hs_rdy_low", 64'(req_ready[0]), 64'd0);
    @(posedge clk);
    #1;
    check("post_hs_rdy", 64'(req_ready[0]), 64'd1);
    check("post_hs_valid", 64'(wb_valid[0]), 64'd0);

    // Reset while waiting for the response; the late response must vanish.
    manual[0] = 1'b1;
    beat(0, 32'h1000, 64'd0);
    @(posedge clk);
    #1;
    req_valid[0] = 1'b1; req_funct3[0] = 3'b000; req_addr[0] = 32'h1003; req_rd[0] = 5'd23;
    accept(0);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1 check_reset_outputs(0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst2_rdy_before", 64'(req_ready[0]), 64'd0);
    @(posedge clk);
    #1;
    check("rst2_rdy_after", 64'(req_ready[0]), 64'd1);
    mem_rsp_valid[0] = 1'b1;
    rsp_lo[0] = 32'h8000_0000;
    @(posedge clk);
    #1 mem_rsp_valid[0] = 1'b0;
    manual[0] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("late_rsp_wb", 64'(wb_valid[0]), 64'd0);
      check("late_rsp_mem", 64'(mem_req_valid[0]), 64'd0);
    end
    beat(0, 32'h1000, 64'h0000_AB00);
    run(0, 3'b100, 32'h1001, 5'd24, 64'h0000_00AB, 1'b0, 3);

    repeat (3) @(posedge clk);
    check("sb_drained", 64'(exp_q.size()), 64'd0);
    check("beats_drained", 64'(beat_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
